// File: rtl/alu_arb_pkg.sv
// Purpose: shared FSM state type and ALU operation codes for the ALU arbiter and its ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_LUI  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd9;
    localparam logic [3:0] OP_SLT  = 4'd10;
    localparam logic [3:0] OP_SLTU = 4'd11;

endpackage

// File: rtl/alu.sv
// Purpose: 32-bit combinational ALU; op codes 12..15 are undefined and produce zero.
// Latency: combinational, zero cycles.
// Backpressure: none; result follows the inputs.
// Ports: ctrl (op code), a (SrcA, also shift amount in a[4:0]), b (SrcB), result.
module alu
    import alu_arb_pkg::*;
(
    input  logic [3:0]  ctrl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    logic [4:0] shamt;
    assign shamt = a[4:0];

    always_comb begin
        result = 32'd0;
        case (ctrl)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SLL:  result = b << shamt;
            OP_SRL:  result = b >> shamt;
            OP_XOR:  result = a ^ b;
            OP_LUI:  result = b << 16;
            OP_SRA:  result = $signed(b) >>> shamt;
            OP_NOR:  result = ~(a | b);
            OP_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            OP_SLTU: result = {31'd0, a < b};
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Purpose: shares one ALU between two requesters, one operation in flight (IDLE -> EXEC -> RESP).
// Latency: accept in IDLE, result registered in EXEC, respN_valid in the following RESP cycle.
// Backpressure: RESP holds until the owner's respN_ready; requests see ready=0 while busy.
// Ports: clk, reset (async, active high); reqN_valid/ready/ctrl/a/b request side,
//        respN_valid/ready/result response side for N in {0,1}; busy = not IDLE.
// Build option: define ALU_ARB_FIXED_PRIO_EN to make port 0 always win a tie
//               (default build is round-robin on a last_grant register).
module alu_arbiter
    import alu_arb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_ctrl,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_ctrl,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic [31:0] resp0_result,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp1_result,
    output logic        busy
);

    state_t      st_q, st_d;
    logic [3:0]  ctrl_q;
    logic [31:0] a_q, b_q, result_q;
    logic        owner_q;
    logic        grant_vld, grant_id;
    logic        accept, resp_fire;
    logic [31:0] alu_dat;

    // Winner selection; only meaningful when grant_vld.
`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant_id  = ~req0_valid;
    end
`else
    logic last_grant_q;

    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid)
            grant_id = ~last_grant_q;
        else if (req1_valid)
            grant_id = 1'b1;
    end

    // Reset to 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant_q <= 1'b1;
        else if (accept)
            last_grant_q <= grant_id;
    end
`endif

    // Ready implies the matching valid, so either ready means a handshake.
    assign accept    = req0_ready | req1_ready;
    assign resp_fire = owner_q ? resp1_ready : resp0_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            st_q <= IDLE;
        else
            st_q <= st_d;
    end

    // Next-state logic.
    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE:    if (accept) st_d = EXEC;
            EXEC:    st_d = RESP;
            RESP:    if (resp_fire) st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    // Output logic. Ready is masked during reset so nothing is accepted while held.
    always_comb begin
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        case (st_q)
            IDLE: if (!reset) begin
                req0_ready = grant_vld & ~grant_id;
                req1_ready = grant_vld &  grant_id;
            end
            RESP: begin
                resp0_valid = ~owner_q;
                resp1_valid =  owner_q;
            end
            default: ;
        endcase
    end

    assign busy = (st_q != IDLE);

    // Operand capture on accept, result capture in EXEC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= 4'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            owner_q  <= 1'b0;
            result_q <= 32'd0;
        end else begin
            if (accept) begin
                owner_q <= grant_id;
                ctrl_q  <= grant_id ? req1_ctrl : req0_ctrl;
                a_q     <= grant_id ? req1_a    : req0_a;
                b_q     <= grant_id ? req1_b    : req0_b;
            end
            if (st_q == EXEC)
                result_q <= alu_dat;
        end
    end

    alu u_alu (
        .ctrl   (ctrl_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_dat)
    );

    // Both responders see the one result register; valid tells them which owns it.
    assign resp0_result = result_q;
    assign resp1_result = result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose: self-checking bench for alu_arbiter against a transaction-level reference.
// Latency: n/a (testbench).
// Backpressure: exercises held responses and requests arriving while busy.
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [31:0] resp0_result, resp1_result;
    logic        busy;

    alu_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_ctrl    (req0_ctrl),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_ctrl    (req1_ctrl),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .resp0_valid  (resp0_valid),
        .resp0_ready  (resp0_ready),
        .resp0_result (resp0_result),
        .resp1_valid  (resp1_valid),
        .resp1_ready  (resp1_ready),
        .resp1_result (resp1_result),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pending requests as the requesters see them, plus who was served last.
    bit          p_vld [2];
    logic [3:0]  p_ctrl[2];
    logic [31:0] p_a   [2];
    logic [31:0] p_b   [2];
    int          last_port;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = a[4:0];
        case (c)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a - b;
            4'd4:  return b << sh;
            4'd5:  return b >> sh;
            4'd6:  return a ^ b;
            4'd7:  return b << 16;
            4'd8:  return $signed(b) >>> sh;
            4'd9:  return ~(a | b);
            4'd10: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd11: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int pick();
        if (p_vld[0] && p_vld[1]) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            return 0;
`else
            return 1 - last_port;
`endif
        end
        return p_vld[0] ? 0 : 1;
    endfunction

    task automatic drive_reqs();
        req0_valid = p_vld[0]; req0_ctrl = p_ctrl[0]; req0_a = p_a[0]; req0_b = p_b[0];
        req1_valid = p_vld[1]; req1_ctrl = p_ctrl[1]; req1_a = p_a[1]; req1_b = p_b[1];
    endtask

    task automatic set_op(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        p_vld[p] = 1'b1; p_ctrl[p] = c; p_a[p] = a; p_b[p] = b;
    endtask

    task automatic rand_op(input int p);
        set_op(p, 4'($urandom_range(0, 15)), $urandom, $urandom);
    endtask

    // Entered just after a negedge with the DUT in IDLE; returns in the same situation.
    // g is the port the DUT actually granted (from its ready outputs).
    task automatic serve_one(input int hold, input bit arrive, output int g, output logic [31:0] res);
        int w;
        logic [31:0] exp;
        drive_reqs();
        #1;
        w = pick();
        g = req1_ready ? 1 : 0;
        chk("idle_busy", busy, 0);
        chk("req0_ready_grant", req0_ready, w == 0);
        chk("req1_ready_grant", req1_ready, w == 1);
        exp = alu_ref(p_ctrl[w], p_a[w], p_b[w]);
        p_vld[w] = 1'b0;
        last_port = w;
        @(negedge clk);
        if (arrive) rand_op(w);   // same port asks again while the ALU is busy
        drive_reqs();
        #1;
        chk("exec_busy", busy, 1);
        chk("exec_resp0_valid", resp0_valid, 0);
        chk("exec_resp1_valid", resp1_valid, 0);
        chk("exec_req0_ready", req0_ready, 0);
        chk("exec_req1_ready", req1_ready, 0);
        @(negedge clk);
        #1;
        res = w ? resp1_result : resp0_result;
        chk("resp_owner_valid", w ? resp1_valid : resp0_valid, 1);
        chk("resp_other_valid", w ? resp0_valid : resp1_valid, 0);
        chk("resp_result", res, exp);
        // The non-owner's ready must be ignored.
        if (w == 1) resp0_ready = 1'b1; else resp1_ready = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            chk("hold_valid", w ? resp1_valid : resp0_valid, 1);
            chk("hold_result", w ? resp1_result : resp0_result, exp);
            chk("hold_busy", busy, 1);
            chk("hold_req0_ready", req0_ready, 0);
            chk("hold_req1_ready", req1_ready, 0);
        end
        if (w == 1) resp1_ready = 1'b1; else resp0_ready = 1'b1;
        @(negedge clk);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        #1;
        chk("done_resp0_valid", resp0_valid, 0);
        chk("done_resp1_valid", resp1_valid, 0);
        chk("done_busy", busy, 0);
    endtask

    // Leaves reset released just after a negedge with nothing pending.
    task automatic do_reset();
        reset = 1'b1;
        p_vld[0] = 1'b0; p_vld[1] = 1'b0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;   // must not be accepted under reset
        @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_resp0_valid", resp0_valid, 0);
        chk("rst_resp1_valid", resp1_valid, 0);
        chk("rst_result", resp0_result, 0);
        @(negedge clk);
        reset = 1'b0;
        last_port = 1;
        drive_reqs();
    endtask

    initial begin
        int g, g2;
        logic [31:0] res;
        for (int p = 0; p < 2; p++) begin
            p_vld[p] = 1'b0; p_ctrl[p] = 4'd0; p_a[p] = 32'd0; p_b[p] = 32'd0;
        end
        req0_ctrl = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
        req1_ctrl = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
        do_reset();

        // Lone request on port 0: 5 + 7.
        set_op(0, 4'd2, 32'd5, 32'd7);
        serve_one(0, 1'b0, g, res);
        chk("add_grant", g, 0);
        chk("add_result", res, 32'h0000000C);

        // Both valid straight out of reset: port 0 first, then port 1.
        do_reset();
        set_op(0, 4'd3, 32'd10, 32'd3);
        set_op(1, 4'd6, 32'hFF, 32'h0F);
        serve_one(0, 1'b0, g, res);
        chk("tie_first_grant", g, 0);
        chk("tie_first_result", res, 32'd7);
        serve_one(0, 1'b0, g, res);
        chk("tie_second_grant", g, 1);
        chk("tie_second_result", res, 32'hF0);

        // Both kept requesting for four operations.
        do_reset();
        rand_op(0);
        rand_op(1);
        for (int i = 0; i < 4; i++) begin
            serve_one(0, 1'b1, g, res);
`ifdef ALU_ARB_FIXED_PRIO_EN
            chk("grant_order", g, 0);
`else
            chk("grant_order", g, i % 2);
`endif
        end

        // Owner stalls for three cycles while port 1 waits.
        do_reset();
        set_op(0, 4'd1, 32'h1234_0000, 32'h0000_5678);
        set_op(1, 4'd2, 32'd1, 32'd1);
        serve_one(3, 1'b0, g, res);
        chk("stall_result", res, 32'h1234_5678);
        serve_one(0, 1'b0, g, res);
        chk("stall_next_result", res, 32'd2);

        // Set-less-than signedness and an undefined op.
        set_op(0, 4'd10, 32'hFFFF_FFFF, 32'd1);
        serve_one(0, 1'b0, g, res);
        chk("slt_signed", res, 32'd1);
        set_op(0, 4'd11, 32'hFFFF_FFFF, 32'd1);
        serve_one(0, 1'b0, g, res);
        chk("slt_unsigned", res, 32'd0);
        set_op(1, 4'd13, 32'hFFFF_FFFF, 32'd1);
        serve_one(0, 1'b0, g, res);
        chk("undef_op", res, 32'd0);

        // Reset during EXEC aborts the operation.
        set_op(0, 4'd2, 32'd100, 32'd23);
        drive_reqs();
        #1;
        chk("abort_accept", req0_ready, 1);
        p_vld[0] = 1'b0;
        @(negedge clk);
        drive_reqs();
        #1;
        chk("abort_exec_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_resp0_valid", resp0_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        last_port = 1;
        resp0_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("abort_quiet_valid", resp0_valid | resp1_valid, 0);
            chk("abort_quiet_busy", busy, 0);
        end
        set_op(1, 4'd8, 32'd4, 32'h8000_0000);
        serve_one(1, 1'b0, g, res);
        chk("after_abort_grant", g, 1);
        chk("after_abort_result", res, 32'hF800_0000);

        // Random traffic, including requests raised while busy.
        for (int n = 0; n < 40; n++) begin
            for (int p = 0; p < 2; p++)
                if (!p_vld[p] && $urandom_range(0, 1) == 1) rand_op(p);
            if (!p_vld[0] && !p_vld[1]) rand_op($urandom_range(0, 1));
            serve_one($urandom_range(0, 2), 1'($urandom_range(0, 1)), g2, res);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
